mc_controller: RTL and testbench

- Multi-cycle control sequencer for the MIPS32 core.
- Drives the write enables of the `pc` and `regfile` blocks, the memory request handshake, and the datapath mux selects.
- Advances one instruction at a time through FETCH/DECODE/EXEC/MEM/WB.
- Counts retired instructions and flags unsupported opcodes.

---
 rtl/mc_controller.sv | 217 +++++++++++++++++++++
 tb/tb_mc_controller.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multi-cycle control sequencer for the MIPS32 core: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath control, counts retirements, watches memory.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module mc_controller #(
  parameter int W       = `WORD_LEN,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   op,
  input  logic [5:0]   funct,
  input  logic         zero,
  input  logic         mem_ack,
  output logic         mem_req,
  output logic         mem_we,
  output logic         iord,
  output logic         ir_we,
  output logic         pc_we,
  output logic [1:0]   pc_src,
  output logic         reg_we,
  output logic         reg_dst,
  output logic         mem_to_reg,
  output logic [1:0]   alu_src_b,
  output logic [1:0]   alu_op,
  output logic [2:0]   state,
  output logic         instr_done,
  output logic         illegal,
  output logic         mem_err,
  output logic [W-1:0] retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  state_t         state_q, state_d;
  logic [W-1:0]   retired_q, retired_d;
  logic [CW-1:0]  waitCnt_q, waitCnt_d;
  logic           memErr_q, memErr_d;

  logic isRtype, isAddi, isLw, isSw, isBeq, isJ, isSupported;

  // The ALU decodes funct itself; the sequencer never needs it.
  logic unusedFunct;
  assign unusedFunct = ^funct;

  assign isRtype     = (op == OP_RTYPE);
  assign isAddi      = (op == OP_ADDI);
  assign isLw        = (op == OP_LW);
  assign isSw        = (op == OP_SW);
  assign isBeq       = (op == OP_BEQ);
  assign isJ         = (op == OP_J);
  assign isSupported = isRtype | isAddi | isLw | isSw | isBeq | isJ;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = DECODE;
        end
      end

      // Branch target is precomputed here so EXEC can write it straight into the PC.
      DECODE: begin
        alu_src_b = 2'd3;
        if (isJ) begin
          pc_we      = 1'b1;
          pc_src     = 2'd2;
          instr_done = 1'b1;
          state_d    = FETCH;
        end else if (!isSupported) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end else begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        if (isRtype) begin
          alu_op  = 2'd2;
          state_d = WB;
        end else if (isBeq) begin
          alu_op     = 2'd1;
          pc_src     = 2'd1;
          pc_we      = zero;
          instr_done = 1'b1;
          state_d    = FETCH;
        end else if (isAddi) begin
          alu_src_b = 2'd2;
          state_d   = WB;
        end else if (isLw || isSw) begin
          alu_src_b = 2'd2;
          state_d   = MEM;
        end else begin
          state_d = FETCH;
        end
      end

      MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = isSw;
        if (mem_ack) begin
          if (isLw) begin
            state_d = WB;
          end else begin
            instr_done = 1'b1;
            state_d    = FETCH;
          end
        end
      end

      WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        reg_dst    = isRtype;
        mem_to_reg = isLw;
        state_d    = FETCH;
      end

      default: state_d = FETCH;
    endcase

    // Reset silences every control line so an abandoned instruction writes nothing.
    if (rst) begin
      state_d    = FETCH;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 2'd0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = 2'd0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  // Wait counter saturates at TIMEOUT; the error flag stays up until reset.
  always_comb begin
    waitCnt_d = '0;
    memErr_d  = memErr_q;
    if (mem_req && !mem_ack) begin
      if (waitCnt_q == TMAX) begin
        waitCnt_d = TMAX;
      end else begin
        waitCnt_d = waitCnt_q + 1'b1;
      end
      if (waitCnt_d == TMAX) begin
        memErr_d = 1'b1;
      end
    end
  end

  assign retired_d = instr_done ? (retired_q + W'(1)) : retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      retired_q <= '0;
      waitCnt_q <= '0;
      memErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      waitCnt_q <= waitCnt_d;
      memErr_q  <= memErr_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign mem_err = memErr_q & ~rst;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: a per-instruction reference model predicts state trace,
// latency and control pulses; a monitor gathers what the DUT does and compares at instr_done.
module tb_mc_controller;

  localparam int W  = 4;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [5:0]   op = '0;
  logic [5:0]   funct = '0;
  logic         zero = 1'b0;
  logic         mem_ack = 1'b0;
  logic         mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0]   pc_src;
  logic         reg_we, reg_dst, mem_to_reg;
  logic [1:0]   alu_src_b, alu_op;
  logic [2:0]   state;
  logic         instr_done, illegal, mem_err;
  logic [W-1:0] retired;

  mc_controller #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .instr_done(instr_done),
    .illegal(illegal), .mem_err(mem_err), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] trace;
    int          cycles;
    int          pcWe;
    int          pcSrc;
    int          irWe;
    int          regWe;
    int          regDst;
    int          memToReg;
    int          memWe;
    int          ill;
    int          memReq;
    bit          err;
  } exp_t;

  exp_t sbQ[$];
  int   tests = 0;
  int   fails = 0;
  bit   monOn = 1'b0;
  int   retiredModel = 0;
  bit   errModel = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit isSupported(input int opc);
    return (opc == 0) || (opc == 8) || (opc == 35) || (opc == 43) || (opc == 4) || (opc == 2);
  endfunction

  function automatic logic [63:0] addState(input logic [63:0] t, input int s);
    return (t << 3) | 64'(s);
  endfunction

  // Architectural view: which phases an opcode passes through and what it must write.
  function automatic exp_t model(input int opc, input bit z, input int fs, input int ms);
    exp_t e;
    bit isR  = (opc == 0);
    bit isAd = (opc == 8);
    bit isLw = (opc == 35);
    bit isSw = (opc == 43);
    bit isBq = (opc == 4);
    bit isJ  = (opc == 2);
    e.trace = '0;
    e.cycles = 0;
    for (int i = 0; i <= fs; i++) begin e.trace = addState(e.trace, 0); e.cycles++; end
    e.trace = addState(e.trace, 1); e.cycles++;
    if (isR || isAd || isLw || isSw || isBq) begin e.trace = addState(e.trace, 2); e.cycles++; end
    if (isLw || isSw) begin
      for (int i = 0; i <= ms; i++) begin e.trace = addState(e.trace, 3); e.cycles++; end
    end
    if (isR || isAd || isLw) begin e.trace = addState(e.trace, 4); e.cycles++; end
    e.pcWe     = 1 + (isJ ? 1 : 0) + ((isBq && z) ? 1 : 0);
    e.pcSrc    = isJ ? 2 : ((isBq && z) ? 1 : 0);
    e.irWe     = 1;
    e.regWe    = (isR || isAd || isLw) ? 1 : 0;
    e.regDst   = isR ? 1 : 0;
    e.memToReg = isLw ? 1 : 0;
    e.memWe    = isSw ? ms + 1 : 0;
    e.ill      = isSupported(opc) ? 0 : 1;
    e.memReq   = fs + 1 + ((isLw || isSw) ? ms + 1 : 0);
    e.err      = 1'b0;
    return e;
  endfunction

  // Drives one instruction; fs/ms are the number of unacknowledged request cycles
  // in the fetch and memory phases.
  task automatic applyStimulus(input int opc, input bit z, input int fs, input int ms);
    exp_t e;
    int   st [2];
    int   phase = 0;
    int   reqCnt = 0;
    int   n = 0;
    bit   done = 1'b0;
    bit   isMemOp = (opc == 35) || (opc == 43);
    e = model(opc, z, fs, ms);
    if (fs >= TO || (isMemOp && ms >= TO)) errModel = 1'b1;
    e.err = errModel;
    sbQ.push_back(e);
    st[0] = fs;
    st[1] = ms;
    while (!done && n < 100) begin
      @(negedge clk);
      op    = opc[5:0];
      zero  = z;
      funct = 6'($urandom);
      if (mem_req) mem_ack = (reqCnt == st[(phase > 1) ? 1 : phase]);
      else         mem_ack = ($urandom_range(0, 3) == 0);
      #1;
      done = instr_done;
      if (mem_req) begin
        if (mem_ack) begin phase++; reqCnt = 0; end
        else reqCnt++;
      end
      n++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("[TB] FAIL instr_timeout: op %0h got no instr_done after %0d cycles", opc, n);
    end
  endtask

  task automatic resetDut();
    rst     = 1'b1;
    mem_ack = 1'b1;
    monOn   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      checkOutput("reset_ctrl_zero",
                  {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg,
                   alu_src_b, alu_op, instr_done, illegal, mem_err}, 0);
      checkOutput("reset_state", state, 0);
      checkOutput("reset_retired", retired, 0);
    end
    @(posedge clk);
    #1;
    rst          = 1'b0;
    mem_ack      = 1'b0;
    retiredModel = 0;
    errModel     = 1'b0;
    #1;
    checkOutput("post_reset_state", state, 0);
    checkOutput("post_reset_mem_req", mem_req, 1);
    checkOutput("post_reset_retired", retired, 0);
    monOn = 1'b1;
  endtask

  // Starts an sw and asserts reset in its second MEM cycle.
  task automatic applyAbort();
    int memCycles = 0;
    int n = 0;
    bit aborted = 1'b0;
    while (!aborted && n < 100) begin
      @(negedge clk);
      op      = 6'h2B;
      mem_ack = (state == 3'd0);
      if (state == 3'd3) begin
        memCycles++;
        if (memCycles == 1) begin
          #1;
          checkOutput("abort_sw_mem_we_before", mem_we, 1);
        end else begin
          rst = 1'b1;
          #1;
          monOn = 1'b0;
          checkOutput("abort_mem_we", mem_we, 0);
          checkOutput("abort_mem_req", mem_req, 0);
          checkOutput("abort_writes", {pc_we, reg_we, instr_done}, 0);
          aborted = 1'b1;
        end
      end
      n++;
    end
    if (!aborted) begin
      tests++;
      fails++;
      $display("[TB] FAIL abort_reach_mem: never reached MEM within %0d cycles", n);
    end
    @(posedge clk);
    #1;
    rst          = 1'b0;
    mem_ack      = 1'b0;
    retiredModel = 0;
    errModel     = 1'b0;
    #1;
    checkOutput("abort_state", state, 0);
    checkOutput("abort_mem_err", mem_err, 0);
    checkOutput("abort_retired", retired, 0);
    monOn = 1'b1;
  endtask

  // Monitor: accumulates one instruction's activity and pops the scoreboard at instr_done.
  initial begin
    logic [63:0] trace;
    int cyc, pcWeN, lastSrc, irWeN, regWeN, rDst, m2r, memWeN, illN, reqN;
    exp_t e;
    trace = '0; cyc = 0; pcWeN = 0; lastSrc = 0; irWeN = 0; regWeN = 0;
    rDst = 0; m2r = 0; memWeN = 0; illN = 0; reqN = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!monOn) begin
        trace = '0; cyc = 0; pcWeN = 0; lastSrc = 0; irWeN = 0; regWeN = 0;
        rDst = 0; m2r = 0; memWeN = 0; illN = 0; reqN = 0;
      end else begin
        cyc++;
        trace = addState(trace, int'(state));
        if (pc_we)   begin pcWeN++; lastSrc = int'(pc_src); end
        if (ir_we)   irWeN++;
        if (reg_we)  begin regWeN++; rDst = int'(reg_dst); m2r = int'(mem_to_reg); end
        if (mem_we)  memWeN++;
        if (illegal) illN++;
        if (mem_req) reqN++;
        if (state == 3'd0) checkOutput("fetch_mux", {iord, alu_src_b, alu_op}, {1'b0, 2'd1, 2'd0});
        if (state == 3'd1) checkOutput("decode_alu", {alu_src_b, alu_op}, {2'd3, 2'd0});
        if (state == 3'd3) checkOutput("mem_iord", iord, 1);
        if (instr_done) begin
          if (sbQ.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_done: instr_done with empty scoreboard, op %0h", op);
          end else begin
            e = sbQ.pop_front();
            checkOutput("state_trace", trace, e.trace);
            checkOutput("latency", cyc, e.cycles);
            checkOutput("pc_we_count", pcWeN, e.pcWe);
            checkOutput("pc_src_last", lastSrc, e.pcSrc);
            checkOutput("ir_we_count", irWeN, e.irWe);
            checkOutput("reg_we_count", regWeN, e.regWe);
            checkOutput("reg_dst", rDst, e.regDst);
            checkOutput("mem_to_reg", m2r, e.memToReg);
            checkOutput("mem_we_count", memWeN, e.memWe);
            checkOutput("illegal_count", illN, e.ill);
            checkOutput("mem_req_count", reqN, e.memReq);
            checkOutput("mem_err", mem_err, e.err);
            checkOutput("retired", retired, retiredModel);
            retiredModel = (retiredModel + 1) % (1 << W);
          end
          trace = '0; cyc = 0; pcWeN = 0; lastSrc = 0; irWeN = 0; regWeN = 0;
          rDst = 0; m2r = 0; memWeN = 0; illN = 0; reqN = 0;
        end
      end
    end
  end

  task automatic randomInstr();
    int opc;
    case ($urandom_range(0, 6))
      0: opc = 0;
      1: opc = 8;
      2: opc = 35;
      3: opc = 43;
      4: opc = 4;
      5: opc = 2;
      default: begin
        opc = int'($urandom_range(0, 63));
        while (isSupported(opc)) opc = int'($urandom_range(0, 63));
      end
    endcase
    applyStimulus(opc, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
  endtask

  initial begin
    resetDut();

    applyStimulus(0, 0, 0, 0);
    applyStimulus(35, 0, 0, 2);
    applyStimulus(4, 1, 0, 0);
    applyStimulus(4, 0, 0, 0);
    applyStimulus(2, 0, 0, 0);
    applyStimulus(63, 0, 0, 0);
    applyStimulus(43, 0, 1, 1);
    applyStimulus(8, 1, 2, 0);

    for (int i = 0; i < 40; i++) randomInstr();

    applyStimulus(8, 0, TO - 1, 0);
    applyStimulus(0, 0, TO, 0);
    applyStimulus(43, 0, 0, 2);

    applyAbort();

    applyStimulus(35, 0, 0, TO);
    for (int i = 0; i < 5; i++) randomInstr();

    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("scoreboard_empty", sbQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
